// File: rtl/dsp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// dsp_ctrl_pkg : shared constants and helpers for the DSP issue controller
// rev 1.0
// ============================================================================
package dsp_ctrl_pkg;

  localparam logic [3:0] DEFAULT_STAGE_SEL = 4'b1111;

  localparam int STG_AB  = 0;
  localparam int STG_PRE = 1;
  localparam int STG_M   = 2;
  localparam int STG_P   = 3;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // Width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_result_fifo.sv
`default_nettype none
// ============================================================================
// dsp_result_fifo : circular result buffer decoupling the slice from downstream
// rev 1.0
// ============================================================================
module dsp_result_fifo
  import dsp_ctrl_pkg::*;
#(
  parameter int P_WIDTH    = 48,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [P_WIDTH-1:0] wr_data_i,
  input  logic               rd_en_i,
  output logic [P_WIDTH-1:0] rd_data_o,
  output logic               valid_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  logic [P_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      occ_q, occ_d;
  logic               full;

  assign valid_o   = (occ_q != '0);
  assign full      = (occ_q == DEPTH_C);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    // Pointers wrap explicitly so non-power-of-two depths also work.
    if (wr_en_i) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_en_i) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({wr_en_i, rd_en_i})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && rst && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst || flush_i)
                                  !(wr_en_i && full));

endmodule
`default_nettype wire

// File: rtl/dsp_pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// dsp_pipe_issue_ctrl : credit-based issue, stage CE tracking, result capture
// rev 1.0
// ============================================================================
module dsp_pipe_issue_ctrl
  import dsp_ctrl_pkg::*;
#(
  parameter int                    NUM_STAGES = 4,
  parameter logic [NUM_STAGES-1:0] STAGE_SEL  = NUM_STAGES'(DEFAULT_STAGE_SEL),
  parameter int                    P_WIDTH    = 48,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [NUM_STAGES-1:0] stage_ce_o,
  output logic [NUM_STAGES-1:0] stage_sel_o,
  input  logic [P_WIDTH-1:0]    p_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [P_WIDTH-1:0]    out_data_o,
  output logic                  busy_o
);

  localparam int LAT   = popcount(32'(STAGE_SEL));
  localparam int VLD_W = (LAT > 0) ? LAT : 1;
  localparam int CW    = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

  logic                  run;
  logic                  in_fire;
  logic                  out_fire;
  logic                  cap;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [VLD_W-1:0]      vld_q, vld_d;
  logic [NUM_STAGES-1:0] ce_raw;

  assign run         = rst & ~flush_i;
  // Credits cover both in-flight and buffered results, so capture never overflows.
  assign in_ready_o  = run & (cnt_q < CNT_MAX);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign busy_o      = (cnt_q != '0);
  assign stage_sel_o = STAGE_SEL;
  assign stage_ce_o  = ce_raw & {NUM_STAGES{run}};

  always_comb begin
    vld_d = (vld_q << 1) | VLD_W'(in_fire);
    case ({in_fire, out_fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // Each registered stage is enabled by the valid bit of the registered stage below it.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_ce
    localparam int RANK = popcount(32'(STAGE_SEL) & ((32'd1 << g) - 32'd1));
    if (!STAGE_SEL[g]) begin : g_bypass
      assign ce_raw[g] = 1'b0;
    end else if (RANK == 0) begin : g_first
      assign ce_raw[g] = in_fire;
    end else begin : g_follow
      assign ce_raw[g] = vld_q[RANK-1];
    end
  end

  if (LAT == 0) begin : g_cap_comb
    assign cap = in_fire;
  end else begin : g_cap_reg
    assign cap = vld_q[LAT-1];
  end

  dsp_result_fifo #(
    .P_WIDTH    (P_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .wr_en_i   (cap),
    .wr_data_i (p_in_i),
    .rd_en_i   (out_fire),
    .rd_data_o (out_data_o),
    .valid_o   (out_valid_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dsp_pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dsp_pipe_issue_ctrl : directed self-checking bench for the issue controller
// rev 1.0
// ============================================================================
module tb_dsp_pipe_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  stage_ce;
    logic [3:0]  stage_sel;
    logic [47:0] p_in;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        busy;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [3:0]  b_stage_ce;
    logic [3:0]  b_stage_sel;
    logic [47:0] b_p_in;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [47:0] b_out_data;
    logic        b_busy;

    int checks   = 0;
    int failures = 0;

    dsp_pipe_issue_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .stage_ce_o  (stage_ce),
        .stage_sel_o (stage_sel),
        .p_in_i      (p_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy)
    );

    dsp_pipe_issue_ctrl #(.STAGE_SEL(4'b1010)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (b_flush),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .stage_ce_o  (b_stage_ce),
        .stage_sel_o (b_stage_sel),
        .p_in_i      (b_p_in),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_data_o  (b_out_data),
        .busy_o      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s", tag);
            $error("check %s", tag);
        end
    endtask

    task automatic run_single(input logic [47:0] val);
        tick(); in_valid = 1'b1; out_ready = 1'b1; p_in = '0; #1;
        chk("single_ready", in_ready === 1'b1);
        chk("single_ce0", stage_ce === 4'b0001);
        tick(); in_valid = 1'b0; #1;
        chk("single_ce1", stage_ce === 4'b0010);
        chk("single_busy", busy === 1'b1);
        tick(); #1;
        chk("single_ce2", stage_ce === 4'b0100);
        tick(); #1;
        chk("single_ce3", stage_ce === 4'b1000);
        tick(); p_in = val; #1;
        chk("single_early_valid", out_valid === 1'b0);
        tick(); p_in = '0; #1;
        chk("single_out_valid", out_valid === 1'b1);
        chk("single_out_data", out_data === val);
        tick(); #1;
        chk("single_busy_fall", busy === 1'b0);
        chk("single_valid_fall", out_valid === 1'b0);
    endtask

    initial begin
        int acc;
        int issued;
        int seen;
        int sh[4];
        logic fire;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; p_in = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_p_in = '0;

        tick(); tick(); in_valid = 1'b1; #1;
        chk("rst_in_ready", in_ready === 1'b0);
        chk("rst_out_valid", out_valid === 1'b0);
        chk("rst_busy", busy === 1'b0);
        chk("rst_stage_ce", stage_ce === 4'b0000);
        chk("rst_out_data", out_data === 48'h0);
        chk("rst_stage_sel", stage_sel === 4'b1111);
        in_valid = 1'b0;
        rst = 1'b1;

        run_single(48'h1234);

        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            in_valid = 1'b1;
            p_in = (c >= 4) ? 48'hA0 + 48'(c - 4) : 48'h0;
            #1;
            if (in_ready) acc++;
        end
        chk("bp_accepts", acc === 4);
        chk("bp_in_ready_low", in_ready === 1'b0);
        chk("bp_head", out_data === 48'hA0);
        tick(); in_valid = 1'b0; out_ready = 1'b1; #1;
        chk("bp_ready_same_cycle", in_ready === 1'b0);
        chk("bp_head0", out_data === 48'hA0);
        tick(); out_ready = 1'b0; #1;
        chk("bp_ready_return", in_ready === 1'b1);
        chk("bp_head1_hold", out_data === 48'hA1);
        tick(); out_ready = 1'b1; #1;
        chk("bp_head1", out_data === 48'hA1);
        tick(); #1;
        chk("bp_head2", out_data === 48'hA2);
        tick(); #1;
        chk("bp_head3", out_data === 48'hA3);
        tick(); #1;
        chk("bp_drained_valid", out_valid === 1'b0);
        chk("bp_drained_busy", busy === 1'b0);

        b_out_ready = 1'b1;
        tick(); b_in_valid = 1'b1; #1;
        chk("b_stage_sel", b_stage_sel === 4'b1010);
        chk("b_ce_issue", b_stage_ce === 4'b0010);
        tick(); b_in_valid = 1'b0; #1;
        chk("b_ce_next", b_stage_ce === 4'b1000);
        chk("b_early_valid", b_out_valid === 1'b0);
        tick(); b_p_in = 48'h77; #1;
        chk("b_ce_idle", b_stage_ce === 4'b0000);
        chk("b_early_valid2", b_out_valid === 1'b0);
        tick(); b_p_in = '0; #1;
        chk("b_out_valid", b_out_valid === 1'b1);
        chk("b_out_data", b_out_data === 48'h77);
        tick(); #1;
        chk("b_busy_fall", b_busy === 1'b0);

        out_ready = 1'b1;
        issued = 0; seen = 0;
        for (int k = 0; k < 4; k++) sh[k] = -1;
        for (int c = 0; c < 80 && seen < 16; c++) begin
            tick();
            in_valid = (issued < 16);
            p_in = (sh[3] >= 0) ? 48'(sh[3]) : 48'hFFFF;
            #1;
            if (out_valid) begin
                chk("stream_order", out_data === 48'(seen));
                seen++;
            end
            fire = in_valid && in_ready;
            sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0];
            sh[0] = fire ? issued : -1;
            if (fire) issued++;
        end
        chk("stream_issued", issued === 16);
        chk("stream_seen", seen === 16);
        tick(); in_valid = 1'b0; #1;
        chk("stream_busy_end", busy === 1'b0);

        out_ready = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            tick();
            in_valid = (c < 4);
            p_in = (c == 4) ? 48'hB0 : (c == 5) ? 48'hB1 : (c == 6) ? 48'hB2 : 48'h0;
            flush = (c == 6);
            #1;
        end
        chk("fl_pre_valid", out_valid === 1'b1);
        chk("fl_pre_head", out_data === 48'hB0);
        chk("fl_pre_busy", busy === 1'b1);
        chk("fl_ce_gated", stage_ce === 4'b0000);
        chk("fl_in_ready", in_ready === 1'b0);
        tick(); flush = 1'b0; in_valid = 1'b0; p_in = 48'hDEAD; #1;
        chk("fl_out_valid", out_valid === 1'b0);
        chk("fl_busy", busy === 1'b0);
        chk("fl_out_data", out_data === 48'h0);
        chk("fl_ce_after", stage_ce === 4'b0000);
        chk("fl_in_ready_back", in_ready === 1'b1);
        tick(); #1;
        chk("fl_no_stale", out_valid === 1'b0);
        run_single(48'hC0);

        out_ready = 1'b0;
        tick(); in_valid = 1'b1; p_in = 48'hDEAD; #1;
        tick(); #1;
        tick(); rst = 1'b0; #1;
        chk("mr_in_ready", in_ready === 1'b0);
        chk("mr_ce", stage_ce === 4'b0000);
        tick(); rst = 1'b1; in_valid = 1'b0; #1;
        chk("mr_out_valid", out_valid === 1'b0);
        chk("mr_busy", busy === 1'b0);
        chk("mr_out_data", out_data === 48'h0);
        chk("mr_ce_after", stage_ce === 4'b0000);
        chk("mr_in_ready_back", in_ready === 1'b1);
        run_single(48'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
